// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT,
      REQ,
      WAIT,
      HOLD
   } fetch_state_t;

   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/plus4.sv
// Sequential-address adder: y = a + 4, wrapping modulo 2^XLEN.
module plus4 #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   output logic [XLEN-1:0] y
);

   assign y = a + XLEN'(4);

endmodule

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer: one outstanding imem read at a time, redirect
// handling with squash of wrong-path responses, valid/ready hand-off to decode.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_inst,
   output logic [XLEN-1:0] if_pc_plus4
);

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_seq;
   logic [XLEN-1:0] target;
   logic            squash;

   assign target = redirect_pc & PC_ALIGN_MASK;

   plus4 #(.XLEN(XLEN)) u_pc_inc (.a(pc),    .y(pc_seq));
   plus4 #(.XLEN(XLEN)) u_link   (.a(if_pc), .y(if_pc_plus4));

   assign imem_req_valid = (state == REQ);
   assign imem_addr      = pc;

   // A redirect always wins over the sequential path; a request already
   // accepted for the old PC is marked squashed so its response is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= BOOT;
         pc       <= RESET_PC;
         squash   <= 1'b0;
         if_valid <= 1'b0;
         if_inst  <= NOP_INST;
         if_pc    <= RESET_PC;
      end else begin
         case (state)
            BOOT: begin
               if (redirect_valid) pc <= target;
               state <= REQ;
            end
            REQ: begin
               if (redirect_valid) begin
                  pc <= target;
                  if (imem_req_ready) begin
                     squash <= 1'b1;
                     state  <= WAIT;
                  end
               end else if (imem_req_ready) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (redirect_valid) begin
                  pc <= target;
                  if (imem_rsp_valid) begin
                     squash <= 1'b0;
                     state  <= REQ;
                  end else begin
                     squash <= 1'b1;
                  end
               end else if (imem_rsp_valid) begin
                  if (squash) begin
                     squash <= 1'b0;
                     state  <= REQ;
                  end else begin
                     if_inst  <= imem_rsp_data;
                     if_pc    <= pc;
                     if_valid <= 1'b1;
                     state    <= HOLD;
                  end
               end
            end
            HOLD: begin
               // A same-cycle decode handshake still transfers; decode kills it.
               if (redirect_valid) begin
                  pc       <= target;
                  if_valid <= 1'b0;
                  state    <= REQ;
               end else if (if_ready) begin
                  pc       <= pc_seq;
                  if_valid <= 1'b0;
                  state    <= REQ;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a model queue holds the next PC decode
// must receive; a monitor pops and checks every decode transfer.
module tb_fetch_ctrl;

   localparam logic [31:0] KEY = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_addr, imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid, if_ready;
   logic [31:0] if_pc, if_inst, if_pc_plus4;

   logic        w_req_valid, w_req_ready, w_rsp_valid;
   logic [31:0] w_addr, w_rsp_data;
   logic        w_redirect_valid;
   logic [31:0] w_redirect_pc;
   logic        w_if_valid, w_if_ready;
   logic [31:0] w_if_pc, w_if_inst, w_if_plus4;

   int          total = 0;
   int          bad = 0;
   int          cycle = 0;
   int          mem_rand = 0;
   logic [31:0] sbq[$];
   int          xfer_cycles[$];

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
      .if_inst(if_inst), .if_pc_plus4(if_pc_plus4)
   );

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(rst),
      .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
      .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
      .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
      .if_valid(w_if_valid), .if_ready(w_if_ready), .if_pc(w_if_pc),
      .if_inst(w_if_inst), .if_pc_plus4(w_if_plus4)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cycle++;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: data = addr ^ KEY, latency 1 (or 1..3 when randomised).
   initial begin
      logic [31:0] a;
      int          lat;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst && imem_req_valid && imem_req_ready) begin
            a   = imem_addr;
            lat = (mem_rand != 0) ? int'($urandom_range(1, 3)) : 1;
            @(posedge clk);
            repeat (lat - 1) @(posedge clk);
            #2;
            if (!rst) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = a ^ KEY;
            end
            @(posedge clk);
            #2 imem_rsp_valid = 1'b0;
         end
      end
   end

   initial begin
      logic [31:0] a;
      w_rsp_valid = 1'b0;
      w_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst && w_req_valid && w_req_ready) begin
            a = w_addr;
            @(posedge clk);
            #2;
            if (!rst) begin
               w_rsp_valid = 1'b1;
               w_rsp_data  = a ^ KEY;
            end
            @(posedge clk);
            #2 w_rsp_valid = 1'b0;
         end
      end
   end

   // Monitor: each decode transfer must carry the PC at the head of the model queue.
   initial forever begin
      logic [31:0] e;
      @(negedge clk);
      if (!rst && if_valid && if_ready) begin
         if (sbq.size() == 0) begin
            checkOutput("sb_nonempty", 32'(sbq.size()), 32'd1);
         end else begin
            e = sbq.pop_front();
            checkOutput("xfer_pc", if_pc, e);
            checkOutput("xfer_inst", if_inst, e ^ KEY);
            checkOutput("xfer_plus4", if_pc_plus4, e + 32'd4);
            sbq.push_back(e + 32'd4);
         end
         xfer_cycles.push_back(cycle);
      end
   end

   task automatic waitReqHandshake(input string name);
      int n = 0;
      @(negedge clk);
      while (!(imem_req_valid && imem_req_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 32'(imem_req_valid && imem_req_ready), 32'd1);
   endtask

   task automatic waitReqValid(input string name);
      int n = 0;
      @(negedge clk);
      while (!imem_req_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 32'(imem_req_valid), 32'd1);
   endtask

   task automatic waitIfValid(input string name);
      int n = 0;
      @(negedge clk);
      while (!if_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 32'(if_valid), 32'd1);
   endtask

   task automatic waitXfers(input int target, input string name);
      int n = 0;
      @(negedge clk);
      #1;
      while (xfer_cycles.size() < target && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput(name, 32'(xfer_cycles.size() >= target), 32'd1);
   endtask

   task automatic applyStimulus(input logic [31:0] tgt);
      @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      @(negedge clk);
      #1;
      sbq.delete();
      sbq.push_back(tgt & 32'hFFFF_FFFC);
      @(posedge clk);
      #1 redirect_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] hold_pc;
      logic [31:0] r;
      int          n0;

      rst = 1'b1;
      imem_req_ready = 1'b1;
      if_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      w_req_ready = 1'b1;
      w_if_ready = 1'b1;
      w_redirect_valid = 1'b0;
      w_redirect_pc = '0;
      sbq.push_back(32'h0);

      #1;
      checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
      checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("rst_if_inst", if_inst, NOP);
      checkOutput("rst_if_pc", if_pc, 32'h0);
      checkOutput("rst_plus4", if_pc_plus4, 32'h4);
      checkOutput("rst_wrap_if_pc", w_if_pc, 32'hFFFF_FFFC);

      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      checkOutput("boot_req_valid", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      checkOutput("first_req_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("first_addr", imem_addr, 32'h0);
      checkOutput("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
      repeat (2) @(negedge clk);
      checkOutput("wrap_if_valid", 32'(w_if_valid), 32'd1);
      checkOutput("wrap_if_pc", w_if_pc, 32'hFFFF_FFFC);
      checkOutput("wrap_plus4", w_if_plus4, 32'h0);
      checkOutput("wrap_if_inst", w_if_inst, 32'hFFFF_FFFC ^ KEY);
      @(negedge clk);
      checkOutput("wrap_next_req", 32'(w_req_valid), 32'd1);
      checkOutput("wrap_next_addr", w_addr, 32'h0);

      waitXfers(4, "seq_xfers_seen");
      for (int i = 1; i < 4; i++)
         checkOutput("seq_gap", 32'(xfer_cycles[i] - xfer_cycles[i-1]), 32'd3);

      // Backpressure: held instruction must stay put with no new request.
      @(posedge clk);
      #1 if_ready = 1'b0;
      waitIfValid("bp_valid_seen");
      hold_pc = sbq[0];
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_if_valid", 32'(if_valid), 32'd1);
         checkOutput("bp_if_pc", if_pc, hold_pc);
         checkOutput("bp_if_inst", if_inst, hold_pc ^ KEY);
         checkOutput("bp_no_req", 32'(imem_req_valid), 32'd0);
         @(negedge clk);
      end
      n0 = xfer_cycles.size();
      @(posedge clk);
      #1 if_ready = 1'b1;
      @(negedge clk);
      #1;
      @(negedge clk);
      #1;
      checkOutput("bp_one_xfer", 32'(xfer_cycles.size() - n0), 32'd1);

      // Redirect while waiting for a response.
      waitReqHandshake("rw_hs_seen");
      applyStimulus(32'h0000_0200);
      waitReqValid("rw_req_seen");
      checkOutput("rw_addr", imem_addr, 32'h0000_0200);
      waitXfers(xfer_cycles.size() + 1, "rw_xfer_seen");

      // Redirect while holding, misaligned target.
      @(posedge clk);
      #1 if_ready = 1'b0;
      waitIfValid("rh_valid_seen");
      applyStimulus(32'h0000_0103);
      @(negedge clk);
      checkOutput("rh_if_valid", 32'(if_valid), 32'd0);
      checkOutput("rh_req_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("rh_addr", imem_addr, 32'h0000_0100);
      @(posedge clk);
      #1 if_ready = 1'b1;
      waitXfers(xfer_cycles.size() + 1, "rh_xfer_seen");

      // Asynchronous reset between edges while waiting.
      waitReqHandshake("ar_hs_seen");
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("ar_if_valid", 32'(if_valid), 32'd0);
      checkOutput("ar_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("ar_if_pc", if_pc, 32'h0);
      checkOutput("ar_if_inst", if_inst, NOP);
      sbq.delete();
      sbq.push_back(32'h0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("ar_boot_req", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      checkOutput("ar_req_valid2", 32'(imem_req_valid), 32'd1);
      checkOutput("ar_addr", imem_addr, 32'h0);
      waitXfers(xfer_cycles.size() + 1, "ar_xfer_seen");

      // Reset while holding an instruction, then redirect during BOOT.
      @(posedge clk);
      #1 if_ready = 1'b0;
      waitIfValid("hr_valid_seen");
      #2 rst = 1'b1;
      #1;
      checkOutput("hr_if_valid", 32'(if_valid), 32'd0);
      checkOutput("hr_if_inst", if_inst, NOP);
      sbq.delete();
      sbq.push_back(32'h44);
      @(posedge clk);
      #1;
      rst = 1'b0;
      if_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h44;
      @(posedge clk);
      #1 redirect_valid = 1'b0;
      @(negedge clk);
      checkOutput("br_req_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("br_addr", imem_addr, 32'h44);
      waitXfers(xfer_cycles.size() + 1, "br_xfer_seen");

      // Randomised traffic against the scoreboard.
      mem_rand = 1;
      n0 = xfer_cycles.size();
      repeat (400) begin
         @(posedge clk);
         #1;
         imem_req_ready = ($urandom_range(0, 3) != 0);
         if_ready = ($urandom_range(0, 2) != 0);
         redirect_valid = ($urandom_range(0, 9) == 0);
         r = $urandom;
         redirect_pc = r[0] ? {24'hFF_FFFF, r[15:8]} : (r & 32'h0000_03FF);
         @(negedge clk);
         #1;
         if (redirect_valid) begin
            sbq.delete();
            sbq.push_back(redirect_pc & 32'hFFFF_FFFC);
         end
      end
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      if_ready = 1'b1;
      checkOutput("rand_progress", 32'(xfer_cycles.size() - n0 > 10), 32'd1);
      waitXfers(xfer_cycles.size() + 2, "drain_xfer_seen");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Program-counter sequencer for the RV32I fetch stage.
- Holds the PC, issues one instruction-memory read at a time using a valid/ready request and valid response, and presents each fetched instruction to decode with a valid/ready handshake.
- Applies branch/jump redirects from execute and squashes wrong-path fetches.
- The sequential PC increment uses the existing plus4 adder.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
XLEN, 32, address/data width (only 32 supported)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, asynchronous, active-high
imem_req_valid  out  1  read request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  request address, word aligned
imem_rsp_valid  in  1  read data valid, exactly one per accepted request
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  branch/jump taken, single-cycle pulse
redirect_pc  in  32  target address
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts
if_pc  out  32  PC of presented instruction
if_inst  out  32  presented instruction
if_pc_plus4  out  32  if_pc + 4, link value for JAL/JALR

Behaviour:
- Reset is async: state=BOOT, pc=RESET_PC, squash=0, if_valid=0, if_inst=32'h0000_0013 (NOP), if_pc=RESET_PC, imem_req_valid=0. imem shares rst, so no response is in flight after reset.
- States:
  - BOOT: one cycle after reset release -> REQ.
  - REQ: imem_req_valid=1, imem_addr=pc. On req handshake -> WAIT.
  - WAIT: await imem_rsp_valid.
    - If squash=0: capture if_inst<=rsp_data, if_pc<=pc, if_valid<=1 -> HOLD.
    - If squash=1: drop data, squash<=0 -> REQ.
  - HOLD: if_valid=1. On if handshake: pc<=pc+4 (plus4), if_valid<=0 -> REQ.
- Latency with a 1-cycle memory: req accept cycle n, rsp cycle n+1, if_valid high cycle n+2, next req cycle n+3 if if_ready=1. Throughput is 1 instruction per 3 cycles; no prefetch.
- Redirect handling. The target is always aligned: pc<=redirect_pc & ~3; bits [1:0] are ignored.
  - REQ without req handshake that cycle: pc<=target, stay REQ. imem_addr may change while valid is high; memory is built to tolerate this.
  - REQ with req handshake the same cycle: pc<=target, squash<=1 -> WAIT.
  - WAIT: pc<=target, squash<=1. If rsp arrives the same cycle, drop it -> REQ with squash<=0.
  - HOLD: pc<=target, if_valid<=0 -> REQ. A simultaneous if handshake still counts as transferred; decode is responsible for killing it.
  - BOOT: pc<=target; the first request goes to the target.
- Wrap-around: PC arithmetic is mod 2^32. 0xFFFF_FFFC + 4 = 0x0000_0000; if_pc_plus4 wraps the same way.
- Every output is registered except if_pc_plus4 (plus4 of if_pc) and imem_req_valid/imem_addr (decoded from state/pc).
- Reset asserted mid-operation discards all state immediately, including any held instruction and squash.

Decomposition:
- Package fetch_pkg:
  - state enum {BOOT, REQ, WAIT, HOLD}, 2 bits
  - NOP_INST=32'h0000_0013
  - PC_ALIGN_MASK=32'hFFFF_FFFC
  - default RESET_PC
- Sub-module: plus4, two instances, one for the pc increment and one for if_pc_plus4. No other sub-modules.

Test Plan:
- Sequential fetch: reset RESET_PC=0; memory returns addr^32'hA5A5_0000 with 1-cycle latency; if_ready=1 -> if_pc 0,4,8,12 with matching if_inst; one if_valid every 3 cycles; if_pc_plus4 = 4,8,12,16.
- Backpressure: hold if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc=0x8 and if_inst stable; no imem_req_valid; one transfer after release.
- Redirect in WAIT: request at 0x10 accepted, redirect_pc=0x200 next cycle -> response for 0x10 never appears on if_*; next imem_addr=0x200; if_pc=0x200.
- Redirect in HOLD with misaligned target 0x103 -> if_valid drops next cycle; next imem_addr=0x100.
- Wrap: RESET_PC=0xFFFF_FFFC -> first if_pc=0xFFFF_FFFC, if_pc_plus4=0; next imem_addr=0x0.
- Async reset mid-WAIT: assert rst between edges -> if_valid=0 and imem_req_valid=0 immediately; after release, BOOT then imem_addr=RESET_PC.
